// File: rtl/pulse_gen_pkg.sv
// ============================================================================
// Module      : pulse_gen_pkg
// Description : Shared mode and state encodings for the pulse-train generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_gen_pkg;

    typedef logic [1:0] mode_t;
    typedef logic [1:0] state_t;

    localparam mode_t  MODE_SINGLE = 2'd0;
    localparam mode_t  MODE_BURST  = 2'd1;
    localparam mode_t  MODE_CONT   = 2'd2;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_HIGH     = 2'd1;
    localparam state_t ST_LOW      = 2'd2;

endpackage : pulse_gen_pkg

`default_nettype wire

// File: rtl/phase_counter.sv
// ============================================================================
// Module      : phase_counter
// Description : Loadable down-counter; load wins over decrement, holds at 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         is_zero
);

    logic [W-1:0] r_value;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= load_val;
        end else if (dec && (r_value != '0)) begin
            r_value <= r_value - 1'b1;
        end
    end

    assign value   = r_value;
    assign is_zero = (r_value == '0);

endmodule : phase_counter

`default_nettype wire

// File: rtl/pulse_train_gen.sv
// ============================================================================
// Module      : pulse_train_gen
// Description : Programmable single/burst/continuous registered pulse train.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] high_len,
    input  logic [LEN_W-1:0] low_len,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic             signal,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] c_ONE_PULSE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Phase length L occupies L cycles, so the counter is loaded with max(L,1)-1.
    function automatic logic [LEN_W-1:0] len_m1(input logic [LEN_W-1:0] v);
        return (v == '0) ? '0 : (v - 1'b1);
    endfunction

    state_t           r_state;
    state_t           w_next;
    mode_t            r_mode;
    logic [LEN_W-1:0] r_high_len;
    logic [LEN_W-1:0] r_low_len;
    logic             r_stop_pend;
    logic             r_signal;
    logic             r_busy;
    logic             r_done;

    mode_t            w_mode_in;
    logic             w_accept;
    logic             w_end;
    logic             w_stop_now;
    logic             w_last;

    logic             w_ph_load;
    logic [LEN_W-1:0] w_ph_val;
    logic             w_ph_dec;
    logic [LEN_W-1:0] w_ph_q;
    logic             w_ph_zero;

    logic             w_pl_load;
    logic [CNT_W-1:0] w_pl_val;
    logic             w_pl_dec;
    logic [CNT_W-1:0] w_pl_q;
    logic             w_pl_zero;

    logic             w_signal_d;
    logic             w_busy_d;
    logic             w_done_d;

    assign w_mode_in  = ((mode == MODE_BURST) || (mode == MODE_CONT)) ? mode : MODE_SINGLE;
    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_end      = (r_state == ST_LOW) && w_ph_zero;
    // A stop arriving in the final low cycle still ends the train at this pulse.
    assign w_stop_now = r_stop_pend | stop;

    always_comb begin
        w_last = 1'b1;
        case (r_mode)
            MODE_CONT:  w_last = w_stop_now;
            MODE_BURST: w_last = w_stop_now || (w_pl_q == c_ONE_PULSE) || w_pl_zero;
            default:    w_last = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start)     w_next = ST_HIGH;
            ST_HIGH: if (w_ph_zero) w_next = ST_LOW;
            ST_LOW:  if (w_ph_zero) w_next = w_last ? ST_IDLE : ST_HIGH;
            default:                w_next = ST_IDLE;
        endcase
    end

    // Output and counter-control logic
    always_comb begin
        w_ph_load  = 1'b0;
        w_ph_val   = '0;
        w_ph_dec   = 1'b0;
        w_pl_load  = 1'b0;
        w_pl_val   = c_ONE_PULSE;
        w_pl_dec   = 1'b0;
        w_signal_d = (w_next == ST_HIGH);
        w_busy_d   = (w_next != ST_IDLE);
        w_done_d   = (r_state == ST_LOW) && (w_next == ST_IDLE);

        if (w_accept) begin
            w_ph_load = 1'b1;
            w_ph_val  = len_m1(high_len);
            w_pl_load = 1'b1;
            if (w_mode_in == MODE_BURST) begin
                w_pl_val = (burst_cnt == '0) ? c_ONE_PULSE : burst_cnt;
            end
        end else if ((r_state == ST_HIGH) && w_ph_zero) begin
            w_ph_load = 1'b1;
            w_ph_val  = len_m1(r_low_len);
        end else if (w_end) begin
            w_ph_load = !w_last;
            w_ph_val  = len_m1(r_high_len);
            w_pl_dec  = (r_mode == MODE_BURST);
        end else if (r_state != ST_IDLE) begin
            w_ph_dec  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mode      <= MODE_SINGLE;
            r_high_len  <= '0;
            r_low_len   <= '0;
            r_stop_pend <= 1'b0;
            r_signal    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mode     <= w_mode_in;
                r_high_len <= high_len;
                r_low_len  <= low_len;
            end
            if (w_next == ST_IDLE) begin
                r_stop_pend <= 1'b0;
            end else if ((r_state != ST_IDLE) && stop) begin
                r_stop_pend <= 1'b1;
            end
            r_signal <= w_signal_d;
            r_busy   <= w_busy_d;
            r_done   <= w_done_d;
        end
    end

    phase_counter #(.W(LEN_W)) u_phase_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (w_ph_load),
        .load_val (w_ph_val),
        .dec      (w_ph_dec),
        .value    (w_ph_q),
        .is_zero  (w_ph_zero)
    );

    phase_counter #(.W(CNT_W)) u_pulse_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (w_pl_load),
        .load_val (w_pl_val),
        .dec      (w_pl_dec),
        .value    (w_pl_q),
        .is_zero  (w_pl_zero)
    );

    assign signal = r_signal;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule : pulse_train_gen

`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
// ============================================================================
// Module      : tb_pulse_train_gen
// Description : Directed table-driven bench for pulse_train_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_train_gen;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic [1:0] mode  = 2'd0;
    logic [7:0] high_len  = 8'd0;
    logic [7:0] low_len   = 8'd0;
    logic [7:0] burst_cnt = 8'd0;
    logic       signal;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    pulse_train_gen #(.LEN_W(8), .CNT_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .high_len  (high_len),
        .low_len   (low_len),
        .burst_cnt (burst_cnt),
        .signal    (signal),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    // stop_cyc / dist_cyc: cycle in which stop or a spurious start is driven, -1 for none
    typedef struct {
        logic [1:0] mode;
        int         h;
        int         l;
        int         n;
        int         stop_cyc;
        int         dist_cyc;
        int         exp_pulses;
        int         exp_high;
        int         exp_busy;
        int         exp_done;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  pulses;
        int  hi;
        int  bz;
        int  dcyc;
        int  idle_bad;
        logic prev;
        mode      = v.mode;
        high_len  = v.h[7:0];
        low_len   = v.l[7:0];
        burst_cnt = v.n[7:0];
        start     = 1'b1;
        stop      = (v.stop_cyc == 0);
        tick();
        start  = 1'b0;
        stop   = 1'b0;
        pulses = 0;
        hi     = 0;
        bz     = 0;
        dcyc   = -1;
        prev   = 1'b0;
        for (int c = 1; (c <= 1200) && (dcyc < 0); c++) begin
            if (c == 1) chk($sformatf("v%0d_first_high", idx), int'(signal), 1);
            if (signal && !prev) pulses++;
            prev = signal;
            if (signal) hi++;
            if (busy) bz++;
            if (done) dcyc = c;
            stop = (c == v.stop_cyc);
            if (c == v.dist_cyc) begin
                start     = 1'b1;
                mode      = 2'd2;
                high_len  = 8'd9;
                low_len   = 8'd9;
                burst_cnt = 8'd20;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        stop  = 1'b0;
        chk($sformatf("v%0d_pulses", idx), pulses, v.exp_pulses);
        chk($sformatf("v%0d_high_cycles", idx), hi, v.exp_high);
        chk($sformatf("v%0d_busy_cycles", idx), bz, v.exp_busy);
        chk($sformatf("v%0d_done_cycle", idx), dcyc, v.exp_done);
        idle_bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (signal || busy || done) idle_bad++;
            tick();
        end
        chk($sformatf("v%0d_idle_after_done", idx), idle_bad, 0);
    endtask

    initial begin
        int seen;
        //            mode  H    L  N  stop dist pul high busy done
        vecs[0]  = '{2'd0,   3,  2, 0,  -1, -1,  1,   3,   5,   6};
        vecs[1]  = '{2'd1,   2,  2, 4,  -1, -1,  4,   8,  16,  17};
        vecs[2]  = '{2'd1,   0,  0, 0,  -1, -1,  1,   1,   2,   3};
        vecs[3]  = '{2'd3,   2,  1, 5,  -1, -1,  1,   2,   3,   4};
        vecs[4]  = '{2'd0,   1,  4, 7,  -1, -1,  1,   1,   5,   6};
        vecs[5]  = '{2'd1,   1,  1, 3,  -1, -1,  3,   3,   6,   7};
        vecs[6]  = '{2'd2,   1,  1, 0,   5, -1,  3,   3,   6,   7};
        vecs[7]  = '{2'd2,   3,  2, 0,   1, -1,  1,   3,   5,   6};
        vecs[8]  = '{2'd1,   2,  3, 5,   7, -1,  2,   4,  10,  11};
        vecs[9]  = '{2'd1, 255,  1, 2,  -1, -1,  2, 510, 512, 513};
        vecs[10] = '{2'd2,   2,  0, 0,   4, -1,  2,   4,   6,   7};
        vecs[11] = '{2'd0,   3,  2, 0,  -1,  2,  1,   3,   5,   6};
        vecs[12] = '{2'd1,   2,  2, 3,  -1,  5,  3,   6,  12,  13};
        vecs[13] = '{2'd0,   2,  2, 0,   0, -1,  1,   2,   4,   5};

        reset = 1'b1;
        stop  = 1'b1;
        repeat (3) tick();
        chk("reset_signal", int'(signal), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        reset = 1'b0;
        tick();
        chk("idle_stop_ignored", int'(busy), 0);
        stop = 1'b0;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset in the middle of a burst (N=5, H=4, L=4): cycle 10 is in pulse 2's high phase.
        mode = 2'd1; high_len = 8'd4; low_len = 8'd4; burst_cnt = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("midrst_pre_signal", int'(signal), 1);
        chk("midrst_pre_busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        chk("midrst_signal", int'(signal), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            if (done || busy || signal) seen++;
            tick();
        end
        chk("midrst_no_done_ever", seen, 0);

        // Restart in the done cycle: single H=2 L=1, then single H=1 L=1.
        mode = 2'd0; high_len = 8'd2; low_len = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 0;
        for (int k = 0; (k < 20) && !done; k++) begin
            seen++;
            tick();
        end
        chk("restart_first_done_cycle", seen + 1, 4);
        high_len = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_signal", int'(signal), 1);
        chk("restart_busy", int'(busy), 1);
        chk("restart_done_clear", int'(done), 0);
        tick();
        chk("restart_low", int'(signal), 0);
        chk("restart_low_busy", int'(busy), 1);
        tick();
        chk("restart_done", int'(done), 1);
        chk("restart_done_busy", int'(busy), 0);
        tick();
        chk("restart_done_single", int'(done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pulse_train_gen

`default_nettype wire
